// File: rtl/a0_trace_fifo_pkg.sv
// Shared constants and entry type for the a0 trace FIFO.
// Optional feature macro: A0_TRACE_TIMESTAMP_EN (adds a timestamp to each entry).
package a0_trace_pkg;
  localparam int A0_TRACE_DATA_WIDTH = 32;
  localparam int A0_TRACE_DEPTH      = 8;
  localparam int A0_TRACE_TS_WIDTH   = 16;

  // Default-width view of one queued entry; the top rebuilds it at its own widths.
  typedef struct packed {
`ifdef A0_TRACE_TIMESTAMP_EN
    logic [A0_TRACE_TS_WIDTH-1:0]   ts;
`endif
    logic [A0_TRACE_DATA_WIDTH-1:0] data;
  } a0_trace_entry_t;
endpackage

// File: rtl/a0_trace_fifo_if.sv
// Host-side stream of captured a0 values plus occupancy/overflow status.
// Optional feature macro: A0_TRACE_TIMESTAMP_EN (adds out_ts).
interface a0_trace_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16
);
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]      out_ts;
`endif

  modport master (
    output out_data, out_valid, count, overflow,
`ifdef A0_TRACE_TIMESTAMP_EN
    output out_ts,
`endif
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, count, overflow,
`ifdef A0_TRACE_TIMESTAMP_EN
    input  out_ts,
`endif
    output out_ready
  );
endinterface

// File: rtl/a0_trace_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO with an explicit occupancy counter.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo
  import a0_trace_pkg::*;
#(
  parameter type T     = a0_trace_entry_t,
  parameter int  DEPTH = A0_TRACE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being vacated by the pop is the one written.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/a0_trace_fifo.sv
// Captures every change of the CPU a0 register into a FIFO and streams the
// queued values to the host. Sticky overflow flags a dropped change.
// Optional feature macro: A0_TRACE_TIMESTAMP_EN (free-running cycle stamp per entry).
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int DATA_WIDTH = A0_TRACE_DATA_WIDTH,
  parameter int DEPTH      = A0_TRACE_DEPTH,
  parameter int TS_WIDTH   = A0_TRACE_TS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic                  en,
  a0_trace_if.master            tr
);
  typedef struct packed {
`ifdef A0_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts;
`endif
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_cfg
    $error("a0_trace_fifo: DEPTH must be a power of two >= 2 and TS_WIDTH >= 1");
  end

  logic [DATA_WIDTH-1:0] last_a0;
  logic                  push, pop, full, empty, overflow_q;
  entry_t                wr_entry, rd_entry;

  assign push = en && (a0 != last_a0);
  assign pop  = !empty && tr.out_ready;

  // Previous-cycle a0, tracked unconditionally so gaps in en don't cause stale pushes.
  always_ff @(posedge clk) begin
    if (rst) last_a0 <= '0;
    else     last_a0 <= a0;
  end

  // Sticky flag: a change arrived while full and nothing left on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                        overflow_q <= 1'b0;
    else if (push && full && !pop)  overflow_q <= 1'b1;
  end

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  // Free-running cycle counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // Assemble the entry written on a push.
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = a0;
`ifdef A0_TRACE_TIMESTAMP_EN
    wr_entry.ts   = ts_cnt;
`endif
  end

  sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (tr.count),
    .full  (full),
    .empty (empty)
  );

  assign tr.out_data  = rd_entry.data;
  assign tr.out_valid = !empty;
  assign tr.overflow  = overflow_q;
`ifdef A0_TRACE_TIMESTAMP_EN
  assign tr.out_ts    = rd_entry.ts;
`endif
endmodule

// File: tb/tb_a0_trace_fifo.sv
// Bench for a0_trace_fifo: directed vector table, hand sequences for
// overflow / full-with-pop / reset, then random traffic against a queue model.
module tb_a0_trace_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [DW-1:0] a0  = '0;

  a0_trace_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) tif ();

  a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk (clk),
    .rst (rst),
    .a0  (a0),
    .en  (en),
    .tr  (tif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending values, previous a0, sticky flag, cycle stamp.
  logic [DW-1:0]  mq[$];
  logic [TSW-1:0] tq[$];
  logic [DW-1:0]  m_last = '0;
  bit             m_ovf  = 1'b0;
  logic [TSW-1:0] m_ts   = '0;

  typedef struct {
    bit            r;
    logic [DW-1:0] a;
    bit            e;
    bit            rdy;
    bit            v;
    int            cnt;
    bit            ovf;
    logic [DW-1:0] d;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [DW-1:0] v, input bit e, input bit rdy);
    bit pop, push;
    if (r) begin
      mq.delete(); tq.delete();
      m_last = '0; m_ovf = 1'b0; m_ts = '0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = e && (v != m_last);
      if (pop) begin
        void'(mq.pop_front());
        void'(tq.pop_front());
      end
      if (push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(v);
          tq.push_back(m_ts);
        end else m_ovf = 1'b1;
      end
      m_last = v;
      m_ts++;
    end
  endtask

  // Apply inputs for one cycle, advance the model, land #1 after the edge.
  task automatic drive(input bit r, input logic [DW-1:0] v, input bit e, input bit rdy);
    rst = r; a0 = v; en = e; tif.out_ready = rdy;
    model_edge(r, v, e, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m_valid", 64'(tif.out_valid), 64'(mq.size() != 0));
    chk("m_count", 64'(tif.count), 64'(mq.size()));
    chk("m_ovf", 64'(tif.overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("m_data", 64'(tif.out_data), 64'(mq[0]));
`ifdef A0_TRACE_TIMESTAMP_EN
      chk("m_ts", 64'(tif.out_ts), 64'(tq[0]));
`endif
    end
  endtask

  initial begin
    int pct;
    tif.out_ready = 1'b0;

    // ---- directed vector table: inputs for one cycle, outputs after the edge ----
    vecs.push_back('{1, 0, 1, 0, 0, 0, 0, 0});
    for (int i = 0; i < 10; i++) vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 5, 1, 0, 1, 1, 0, 5});
    vecs.push_back('{0, 5, 1, 0, 1, 1, 0, 5});
    vecs.push_back('{0, 9, 1, 0, 1, 2, 0, 5});
    vecs.push_back('{0, 9, 1, 1, 1, 1, 0, 9});
    vecs.push_back('{0, 9, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 2, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 3, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 3, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 4, 1, 0, 1, 1, 0, 4});
    vecs.push_back('{0, 4, 1, 1, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].a, vecs[i].e, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), 64'(tif.out_valid), 64'(vecs[i].v));
      chk($sformatf("vec%0d_count", i), 64'(tif.count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_ovf", i), 64'(tif.overflow), 64'(vecs[i].ovf));
      if (vecs[i].v) chk($sformatf("vec%0d_data", i), 64'(tif.out_data), 64'(vecs[i].d));
    end

    // ---- overflow: 10 distinct values into 8 entries, then drain ----
    drive(1, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(0, DW'(i), 1, 0);
      chk("ovf_fill_count", 64'(tif.count), 64'((i < DEPTH) ? i : DEPTH));
      chk("ovf_fill_flag", 64'(tif.overflow), 64'(i > DEPTH));
    end
    for (int k = 1; k <= DEPTH; k++) begin
      chk("ovf_drain_data", 64'(tif.out_data), 64'(k));
      drive(0, 10, 1, 1);
    end
    chk("ovf_drained_valid", 64'(tif.out_valid), 64'(0));
    chk("ovf_sticky", 64'(tif.overflow), 64'(1));

    // ---- full FIFO with simultaneous push and pop ----
    drive(1, 0, 1, 0);
    for (int i = 1; i <= DEPTH; i++) drive(0, DW'(100 + i), 1, 0);
    chk("full_count", 64'(tif.count), 64'(DEPTH));
    drive(0, 200, 1, 1);
    chk("fullpp_count", 64'(tif.count), 64'(DEPTH));
    chk("fullpp_ovf", 64'(tif.overflow), 64'(0));
    for (int k = 0; k < DEPTH; k++) begin
      chk("fullpp_drain", 64'(tif.out_data), 64'((k < DEPTH - 1) ? (102 + k) : 200));
      drive(0, 200, 1, 1);
    end
    chk("fullpp_empty", 64'(tif.out_valid), 64'(0));

    // ---- timestamp of a change in cycle 4 after reset ----
    drive(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    drive(0, 7, 1, 0);
`ifdef A0_TRACE_TIMESTAMP_EN
    chk("ts_cycle4", 64'(tif.out_ts), 64'(4));
`endif
    chk("ts_data", 64'(tif.out_data), 64'(7));

    // ---- reset with 3 entries queued, plus an ignored concurrent push ----
    drive(0, 8, 1, 0);
    drive(0, 9, 1, 0);
    chk("pre_rst_count", 64'(tif.count), 64'(3));
    drive(1, 11, 1, 1);
    chk("rst_count", 64'(tif.count), 64'(0));
    chk("rst_ovf", 64'(tif.overflow), 64'(0));
    chk("rst_valid", 64'(tif.out_valid), 64'(0));

    // ---- random traffic against the model ----
    drive(1, 0, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      pct = ((c / 200) % 2 == 0) ? 20 : 85;
      check_model();
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3)),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 99) < pct));
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
